// File: rtl/muladd_load_pkg.sv
// Shared sizes, FSM state and vector tag for the MulAdd load-stream receive path.
package muladd_load_pkg;
  localparam int WORD_W     = 32;
  localparam int ELEM_W     = 16;
  localparam int VEC_LEN    = 16;
  localparam int NUM_LAYERS = 8;
  localparam int L0_VECS    = 32;
  localparam int LN_VECS    = 16;
  localparam int VEC_W      = VEC_LEN * ELEM_W;
  localparam int BEATS      = VEC_W / WORD_W;

  typedef enum logic [1:0] {S_L0, S_LN, S_DONE} state_e;

  typedef struct packed {
    logic       kind;
    logic [2:0] layer;
    logic [3:0] idx;
  } vec_tag_t;
endpackage

// File: rtl/load_vec_assembler.sv
// Beat counter and shift register turning 8 load words into one vector; MSB pair arrives first.
module load_vec_assembler
  import muladd_load_pkg::*;
#(
  parameter int W_WORD = WORD_W,
  parameter int W_VEC  = VEC_W
) (
  input  logic              clk_data,
  input  logic              rst,
  input  logic              beat_en,
  input  logic [W_WORD-1:0] payload,
  output logic              vec_complete,
  output logic [W_VEC-1:0]  vec_data
);
  logic [2:0]              beat;
  logic [W_VEC-W_WORD-1:0] asm_q;

  // Shifting up by one word per beat leaves beat 0 in the top word after beat 7.
  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      beat  <= '0;
      asm_q <= '0;
    end else if (beat_en) begin
      beat  <= beat + 3'd1;
      asm_q <= {asm_q[W_VEC-2*W_WORD-1:0], payload};
    end
  end

  assign vec_complete = beat_en && (beat == 3'(BEATS - 1));
  assign vec_data     = {asm_q, payload};
endmodule

// File: rtl/load_stream_unpacker.sv
// Load-stream receive end: assembles, tags and presents 144 vectors over valid/ready.
// Optional LOAD_CHECKSUM_EN adds a running sum of accepted load words.
module load_stream_unpacker
  import muladd_load_pkg::*;
(
  input  logic              clk_data,
  input  logic              rst,
  input  logic              load_en_i,
  input  logic [WORD_W-1:0] load_payload_i,
  output logic              vec_valid_o,
  input  logic              vec_ready_i,
  output logic [VEC_W-1:0]  vec_data_o,
  output logic              vec_kind_o,
  output logic [2:0]        vec_layer_o,
  output logic [3:0]        vec_idx_o,
  output logic              done_o,
  output logic              ovf_err_o
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o,
  output logic              checksum_valid_o
`endif
);
  state_e           state;
  logic [4:0]       vec_cnt;
  logic [2:0]       layer;
  vec_tag_t         cur_tag, out_tag;
  logic [VEC_W-1:0] out_data, asm_data;
  logic             beat_en, vec_complete, accept, done_set;

  assign beat_en  = load_en_i && (state != S_DONE);
  assign accept   = vec_valid_o && vec_ready_i;
  assign done_set = (state == S_DONE) && (accept || !vec_valid_o);

  load_vec_assembler u_asm (
    .clk_data     (clk_data),
    .rst          (rst),
    .beat_en      (beat_en),
    .payload      (load_payload_i),
    .vec_complete (vec_complete),
    .vec_data     (asm_data)
  );

  // Layer 0 interleaves input rows (even n) with weight columns (odd n).
  always_comb begin
    cur_tag = '0;
    case (state)
      S_L0: begin
        cur_tag.kind = vec_cnt[0];
        cur_tag.idx  = vec_cnt[4:1];
      end
      S_LN: begin
        cur_tag.kind  = 1'b1;
        cur_tag.layer = layer;
        cur_tag.idx   = vec_cnt[3:0];
      end
      default: cur_tag = '0;
    endcase
  end

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      state       <= S_L0;
      vec_cnt     <= '0;
      layer       <= '0;
      vec_valid_o <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      done_o      <= 1'b0;
      ovf_err_o   <= 1'b0;
    end else begin
      if (vec_complete) begin
        case (state)
          S_L0:
            if (vec_cnt == 5'(L0_VECS - 1)) begin
              state   <= S_LN;
              layer   <= 3'd1;
              vec_cnt <= '0;
            end else begin
              vec_cnt <= vec_cnt + 5'd1;
            end
          S_LN:
            if (vec_cnt[3:0] == 4'(LN_VECS - 1)) begin
              // Counter is left at its last value once the stream is finished.
              if (layer == 3'(NUM_LAYERS - 1)) begin
                state <= S_DONE;
              end else begin
                layer   <= layer + 3'd1;
                vec_cnt <= '0;
              end
            end else begin
              vec_cnt <= vec_cnt + 5'd1;
            end
          default: ;
        endcase
      end

      // A completion during an accepting handshake replaces the held vector.
      if (vec_complete && vec_valid_o && !vec_ready_i) begin
        ovf_err_o <= 1'b1;
      end else if (vec_complete) begin
        vec_valid_o <= 1'b1;
        out_data    <= asm_data;
        out_tag     <= cur_tag;
      end else if (accept) begin
        vec_valid_o <= 1'b0;
      end

      if (done_set) done_o <= 1'b1;
    end
  end

  assign vec_data_o  = out_data;
  assign vec_kind_o  = out_tag.kind;
  assign vec_layer_o = out_tag.layer;
  assign vec_idx_o   = out_tag.idx;

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      checksum_o       <= '0;
      checksum_valid_o <= 1'b0;
    end else begin
      if (beat_en) checksum_o <= checksum_o + load_payload_i;
      if (done_set) checksum_valid_o <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_load_stream_unpacker.sv
// Randomized bench for load_stream_unpacker with a stream-level reference model.
module tb_load_stream_unpacker;
  logic         clk_data = 1'b0;
  logic         rst = 1'b1;
  logic         load_en_i = 1'b0;
  logic [31:0]  load_payload_i = '0;
  logic         vec_ready_i = 1'b0;
  logic         vec_valid_o, vec_kind_o, done_o, ovf_err_o;
  logic [255:0] vec_data_o;
  logic [2:0]   vec_layer_o;
  logic [3:0]   vec_idx_o;
`ifdef LOAD_CHECKSUM_EN
  logic [31:0]  checksum_o;
  logic         checksum_valid_o;
`endif

  load_stream_unpacker dut (
    .clk_data       (clk_data),
    .rst            (rst),
    .load_en_i      (load_en_i),
    .load_payload_i (load_payload_i),
    .vec_valid_o    (vec_valid_o),
    .vec_ready_i    (vec_ready_i),
    .vec_data_o     (vec_data_o),
    .vec_kind_o     (vec_kind_o),
    .vec_layer_o    (vec_layer_o),
    .vec_idx_o      (vec_idx_o),
    .done_o         (done_o),
    .ovf_err_o      (ovf_err_o)
`ifdef LOAD_CHECKSUM_EN
    ,
    .checksum_o       (checksum_o),
    .checksum_valid_o (checksum_valid_o)
`endif
  );

  always #5 clk_data = ~clk_data;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tags follow directly from the vector's position n in the 144-vector stream.
  function automatic int kind_of(int n);  return (n < 32) ? n % 2 : 1; endfunction
  function automatic int layer_of(int n); return (n < 32) ? 0 : 1 + (n - 32) / 16; endfunction
  function automatic int idx_of(int n);   return (n < 32) ? n / 2 : (n - 32) % 16; endfunction

  // Model state: words taken from the stream, the held output vector, sticky flags.
  int           m_words;
  logic [31:0]  m_cur [8];
  bit           m_valid, m_done, m_ovf;
  logic [255:0] m_data;
  int           m_n;
  logic [31:0]  m_sum;

  always @(posedge clk_data or posedge rst) begin : model
    bit acc, was_v;
    if (rst) begin
      m_words = 0; m_valid = 0; m_done = 0; m_ovf = 0;
      m_data = '0; m_n = 0; m_sum = '0;
    end else begin
      was_v = m_valid;
      acc   = m_valid && vec_ready_i;
      if (m_words == 1152 && (acc || !was_v)) m_done = 1;
      if (acc) m_valid = 0;
      if (load_en_i && m_words < 1152) begin
        m_sum = m_sum + load_payload_i;
        m_cur[m_words % 8] = load_payload_i;
        m_words++;
        if (m_words % 8 == 0) begin
          if (was_v && !acc) m_ovf = 1;
          else begin
            m_valid = 1;
            m_n = m_words / 8 - 1;
            for (int e = 0; e < 16; e++)
              m_data[e*16 +: 16] = (e % 2 == 1) ? m_cur[(15 - e) / 2][31:16]
                                                : m_cur[(15 - e) / 2][15:0];
          end
        end
      end
    end
  end

  always @(negedge clk_data) begin
    chk("valid", vec_valid_o, m_valid);
    if (m_valid) begin
      chk("data", vec_data_o, m_data);
      chk("kind", vec_kind_o, kind_of(m_n));
      chk("layer", vec_layer_o, layer_of(m_n));
      chk("idx", vec_idx_o, idx_of(m_n));
    end
    chk("done", done_o, m_done);
    chk("ovf", ovf_err_o, m_ovf);
`ifdef LOAD_CHECKSUM_EN
    chk("checksum", checksum_o, m_sum);
    chk("checksum_valid", checksum_valid_o, m_done);
`endif
  end

  task automatic tick();
    if (rand_rdy) vec_ready_i = ($urandom_range(3) != 0);
    @(posedge clk_data);
    #1;
  endtask

  task automatic beat(logic [31:0] w);
    load_en_i = 1'b1;
    load_payload_i = w;
    tick();
    load_en_i = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send_vec(bit gaps);
    for (int b = 0; b < 8; b++) begin
      if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 3));
      beat($urandom);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, vec_valid_o, 0);
    chk({tag, "_data"}, vec_data_o, 0);
    chk({tag, "_tags"}, {vec_kind_o, vec_layer_o, vec_idx_o}, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_ovf"}, ovf_err_o, 0);
`ifdef LOAD_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum_o, 0);
`endif
  endtask

  initial begin
    logic [255:0] exp_v0;
    for (int e = 0; e < 16; e++) exp_v0[e*16 +: 16] = 16'(e);

    idle(2);
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Vector 0: element e carries value e.
    for (int b = 0; b < 8; b++) begin
      if (b == 7) chk("v0_before_last_beat", vec_valid_o, 0);
      beat({16'(15 - 2*b), 16'(14 - 2*b)});
    end
    chk("v0_valid", vec_valid_o, 1);
    chk("v0_data", vec_data_o, exp_v0);
    chk("v0_tags", {vec_kind_o, vec_layer_o, vec_idx_o}, 0);
    vec_ready_i = 1'b1;
    tick();

    // Rest of layer 0; vector 1 has a 3-cycle stall inside it.
    for (int b = 0; b < 8; b++) begin
      if (b == 4) idle(3);
      beat($urandom);
    end
    for (int n = 2; n < 32; n++) send_vec(0);
    idle(1);
    chk("l0_no_ovf", ovf_err_o, 0);
    idle(24);

    // Overflow: vector 33 completes while vector 32 is still held.
    vec_ready_i = 1'b0;
    send_vec(0);
    chk("v32_tags", {vec_kind_o, vec_layer_o, vec_idx_o}, {1'b1, 3'd1, 4'd0});
    send_vec(0);
    chk("ovf_set", ovf_err_o, 1);
    chk("v32_held_idx", vec_idx_o, 0);
    vec_ready_i = 1'b1;
    tick();
    send_vec(0);
    chk("v34_idx", {vec_layer_o, vec_idx_o}, {3'd1, 4'd2});
    tick();

    rand_rdy = 1;
    for (int n = 35; n < 144; n++) send_vec(1);
    rand_rdy = 0;
    vec_ready_i = 1'b1;
    idle(4);
    chk("done_set", done_o, 1);
    for (int k = 0; k < 8; k++) beat($urandom);
    idle(2);
    chk("extra_no_valid", vec_valid_o, 0);

    // Reset in the middle of layer 3 idx 7 (vector 71), after beat 4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int n = 0; n < 71; n++) send_vec(0);
    for (int b = 0; b < 5; b++) beat($urandom);
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    tick();
    rst = 1'b0;
    tick();
    send_vec(0);
    chk("restart_valid", vec_valid_o, 1);
    chk("restart_tags", {vec_kind_o, vec_layer_o, vec_idx_o}, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_stream_unpacker.md
Name: load_stream_unpacker

Overview:
- Receive end of the 32-bit load stream into the MulAdd array, clocked in the clk_data domain.
- Collects 8 consecutive load words into one 16x16-bit vector and tags it with kind, layer and index.
- Presents the vector to the PE-side buffers with a valid/ready handshake.
- Mirrors the loader's packing order exactly: layer 0 alternates input rows and weight columns; layers 1..7 carry weight vectors only.

Parameters:
- WORD_W, 32, load word width; always 2*ELEM_W.
- ELEM_W, 16, element width.
- VEC_LEN, 16, elements per vector.
- NUM_LAYERS, 8, number of weight layers.
- L0_VECS, 32, vectors in layer 0 (16 input plus 16 weight, alternating).
- LN_VECS, 16, weight vectors per layer for layers 1..NUM_LAYERS-1.

Ports:
- clk_data  in  1  clock for all logic.
- rst  in  1  reset, asynchronous, active-high.
- load_en_i  in  1  qualifies load_payload_i for one cycle.
- load_payload_i  in  WORD_W  packed element pair {high, low}.
- vec_valid_o  out  1  assembled vector available.
- vec_ready_i  in  1  consumer accepts the vector on the cycle where vec_valid_o=1 and vec_ready_i=1.
- vec_data_o  out  VEC_LEN*ELEM_W  element e in bits [e*16+:16].
- vec_kind_o  out  1  0 = input row, 1 = weight column/vector.
- vec_layer_o  out  3  layer index 0..7.
- vec_idx_o  out  4  row/column index within kind and layer, 0..15.
- done_o  out  1  all 144 vectors delivered; sticky until reset.
- ovf_err_o  out  1  sticky: a vector completed while the output register was still full.

Behaviour:
- Reset values: all outputs 0. Internal state also clears on reset: beat count, vector count, layer and checksum. Reset asserted mid-vector discards the partial vector.
- Beat order, MSB pair first:
  - Beat b (0..7) writes element 15-2b from payload[31:16] and element 14-2b from payload[15:0].
  - Beat 0 therefore carries elements 15 and 14; beat 7 carries elements 1 and 0.
- Only cycles with load_en_i=1 advance the beat counter. Idle cycles inside a vector or between layers are legal and hold all state.
- Vector completion:
  - On beat 7 the assembly register plus its tags move into the output register, and vec_valid_o rises the next cycle (latency 1 after the last beat).
  - The output register holds until the handshake completes; vec_valid_o then drops, unless a new vector loads in the same cycle, in which case it stays high.
- Tagging (state machine S_L0 -> S_LN -> S_DONE):
  - S_L0: vector n (0..31) gets kind=n[0], idx=n>>1, layer=0. After n=31, go to S_LN with layer=1.
  - S_LN: kind=1, idx=vector count within the layer (0..15). After idx 15, layer increments. After the layer 7, idx 15 vector, go to S_DONE.
  - S_DONE: done_o=1 once the final vector is accepted. Further load_en_i words are ignored.
- Overflow: if beat 7 arrives while vec_valid_o=1 and vec_ready_i=0:
  - The new vector is dropped and ovf_err_o is set (sticky).
  - Counters still advance so tagging stays aligned.
  - Beat 7 in the same cycle as the handshake is NOT overflow; the new vector replaces the accepted one.
- Counter widths: beat 3 bits, wraps 7 -> 0. The vector counter saturates in S_DONE.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- When defined:
  - Adds output checksum_o, 32 bits: the modulo-2^32 sum of every accepted load word (load_en_i=1 and not in S_DONE).
  - checksum_o resets to 0.
  - Adds checksum_valid_o, which rises together with done_o.
- When undefined: neither port nor accumulator exists, and behaviour is otherwise identical.

Decomposition:
- Package muladd_load_pkg holds the parameter defaults, the state enum {S_L0, S_LN, S_DONE}, and the tag struct {kind, layer[2:0], idx[3:0]}.
- One sub-module, load_vec_assembler: the beat counter plus the 256-bit shift/insert register. It outputs a one-cycle vec_complete pulse.
- Tagging, the state machine and the output register stay in the top level.

Test Plan:
- Send 8 beats 0x000F000E, 0x000D000C … 0x00010000 -> vec_data_o element e = e, kind=0, layer=0, idx=0; vec_valid_o high 1 cycle after beat 7.
- Full layer 0 with vec_ready_i tied 1 -> 32 vectors with kinds 0,1,0,1…, idx 0,0,1,1…15,15, no ovf_err_o.
- Insert 3 idle cycles between beats 3 and 4, then a 24-cycle gap before layer 1 -> data and tags unchanged vs the gapless run.
- Hold vec_ready_i=0 across the next vector's beat 7 -> ovf_err_o=1; the held vector stays intact; the next accepted vector has idx advanced by 2.
- Complete all 144 vectors, then send 8 extra words -> done_o=1 after the final handshake; extra words produce no vec_valid_o. With LOAD_CHECKSUM_EN, checksum_o equals the software sum of the 1152 words.
- Assert rst at beat 5 of layer 3 idx 7 -> all outputs 0; a fresh stream restarts at layer 0 idx 0, kind 0.
